rvfi_reorder: RTL
=================

# rvfi_reorder

Reorders out-of-order RVFI retirement packets into a single in-order, one-per-cycle RVFI stream, keyed on `rvfi_order`. It sits between the core's NRET-wide RVFI port and the downstream single-channel checkers (dmem, register, PC-continuity checks). Those checkers therefore see retirements in strict program order. The block also flags protocol violations in the incoming order stream.

## Interface
- `XLEN`, default `RISCV_FORMAL_XLEN`: data/address width.
- `NRET`, default `RISCV_FORMAL_NRET`: input retire lanes.
- `DEPTH`, default 8: reorder slots; power of two, ≥ NRET, ≤ 128.
- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `rvfi_valid`  in  NRET  per-lane retire strobe.
- `rvfi_order`  in  NRET*8  per-lane instruction index.
- `rvfi_*` remaining fields  in  NRET-packed, standard widths:
  - insn
  - rs1/rs2/rd addr
  - pc_rdata, post_pc
  - rs1/rs2 rdata, rd_wdata
  - trap
  - mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata
- `out_valid`  out  1  in-order packet present.
- `out_*`  out  same field set, NRET=1 widths: the emitted packet.
- `occupancy`  out  $clog2(DEPTH)+1  slots currently filled.
- `err_dup`  out  1  sticky: order already buffered, or two lanes carry the same order in one cycle.
- `err_window`  out  1  sticky: order outside `[expected, expected+DEPTH-1]` (mod 256).

## Operation
- State:
  - `expected`: 8-bit, reset 0.
  - DEPTH slots, each a valid bit plus a full packet, indexed by `order[log2(DEPTH)-1:0]`.
  - Output register.
- Acceptance, per valid lane each cycle:
  - Compute `d = order - expected` (8-bit wrap).
  - If `d ≥ DEPTH`: set `err_window`; drop the lane.
  - Else if the slot is occupied, or a lower-numbered lane this cycle has the same order: set `err_dup`; drop the lane. The first lane wins.
  - Else accept.
- Emission, one per cycle:
  - If slot[expected] is valid: load it into the output register, clear the slot, increment `expected`.
  - Otherwise, if an accepted lane this cycle has `order == expected` (bypass): load that lane into the output register, do not write its slot, increment `expected`.
  - Otherwise `out_valid`=0 and `out_*` hold their last value.
- Slot hit and bypass cannot both apply: a same-order input against an occupied slot is a dup and is dropped.
- All other accepted lanes are written to their slots in the same edge.
- Wrap: `expected` 255→0; the window test uses mod-256 difference only.
- Buffer full: no stall is possible. A new order is necessarily out of window or a dup, so it is flagged and dropped.
- Error flags clear only on reset. Erroneous lanes never corrupt existing slots.
- Reset, asserted at any time, asynchronously:
  - slot valid bits → 0
  - `expected` → 0
  - `out_valid` → 0
  - `occupancy` → 0
  - `err_*` → 0
  - `out_*` data → 0

## Timing
- Latency: a lane with `order == expected` at edge k appears with `out_valid`=1 in the cycle after edge k (1 cycle).
- A buffered packet emits on the first edge at which it is `expected`.
- Throughput: at most one output per cycle. Sustained input of more than 1 per cycle fills the buffer, then errors.
- `occupancy` is registered and reflects slot state after each edge (bypassed packets are not counted).
- While `resetn`=0, inputs are ignored.

## Structure
- Shared package `rvfi_pkg`:
  - `rvfi_pkt_t` struct (NRET=1 field set).
  - `ORDER_W`=8.
  - Lane-slice helper for flat NRET buses.
- One sub-module: `rvfi_lane_pick`. Combinational priority select of the lowest lane matching a given order; used for bypass and for dup detection.
- Slot array and `expected` counter live in the top.

## Test plan
- In-order, NRET=2: orders 0,1 at cycle 0; 2,3 at cycle 1 → outputs 0,1,2,3 on cycles 1–4; no errors; peak `occupancy` 2.
- Reverse: orders 3,2,1 then 0 → nothing emitted until order 0 arrives; then 0,1,2,3 on four consecutive cycles; `occupancy` 3→0.
- Wrap: with `expected`=254, feed 255,254,0,1 → outputs 254,255,0,1; `err_window`=0.
- Duplicate: order 5 buffered, then order 5 again → `err_dup`=1; first packet is emitted intact (check `out_insn`).
- Window: DEPTH=8, `expected`=0, order 8 → `err_window`=1; order 7 is accepted.
- Reset mid-stream: slots holding 2,3 plus `resetn` pulsed low for 1 cycle → `out_valid`=0, `occupancy`=0, flags 0 immediately; after release, order 0 emits on the next cycle.

Source files
------------

// File: rtl/rvfi_pkg.sv
// Shared RVFI types: the single-lane retirement packet and flat-bus lane slicing.
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif

package rvfi_pkg;

  localparam int unsigned ORDER_W  = 8;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned PKT_XLEN = `RISCV_FORMAL_XLEN;

  // Packet widths follow the build-wide XLEN; module XLEN parameters must agree with it.
  typedef struct packed {
    logic [ORDER_W-1:0]    order;
    logic [ILEN-1:0]       insn;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [4:0]            rd_addr;
    logic [PKT_XLEN-1:0]   pc_rdata;
    logic [PKT_XLEN-1:0]   post_pc;
    logic [PKT_XLEN-1:0]   rs1_rdata;
    logic [PKT_XLEN-1:0]   rs2_rdata;
    logic [PKT_XLEN-1:0]   rd_wdata;
    logic                  trap;
    logic [PKT_XLEN-1:0]   mem_addr;
    logic [PKT_XLEN/8-1:0] mem_rmask;
    logic [PKT_XLEN/8-1:0] mem_wmask;
    logic [PKT_XLEN-1:0]   mem_rdata;
    logic [PKT_XLEN-1:0]   mem_wdata;
  } rvfi_pkt_t;

  // LSB of lane `lane` in a flat bus whose per-lane field is `width` bits wide.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/rvfi_lane_pick.sv
// Combinational one-hot select of the lowest candidate lane whose order equals target_i.
// Zero latency, no flow control.
module rvfi_lane_pick
  import rvfi_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic [NRET-1:0]         cand_i,
  input  logic [NRET*ORDER_W-1:0] order_i,
  input  logic [ORDER_W-1:0]      target_i,
  output logic [NRET-1:0]         sel_o
);

  always_comb begin
    sel_o = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (cand_i[i] && (order_i[lane_lsb(i, ORDER_W) +: ORDER_W] == target_i)) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfi_reorder.sv
// Reorders NRET-wide out-of-order RVFI retirements into one in-order packet per cycle.
// 1-cycle latency for the expected order; no backpressure: overflow is flagged and dropped.
module rvfi_reorder
  import rvfi_pkg::*;
#(
  parameter int XLEN  = `RISCV_FORMAL_XLEN,
  parameter int NRET  = `RISCV_FORMAL_NRET,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NRET-1:0]          rvfi_valid,
  input  logic [NRET*ORDER_W-1:0]  rvfi_order,
  input  logic [NRET*ILEN-1:0]     rvfi_insn,
  input  logic [NRET*5-1:0]        rvfi_rs1_addr,
  input  logic [NRET*5-1:0]        rvfi_rs2_addr,
  input  logic [NRET*5-1:0]        rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]     rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]     rvfi_post_pc,
  input  logic [NRET*XLEN-1:0]     rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]     rvfi_rs2_rdata,
  input  logic [NRET*XLEN-1:0]     rvfi_rd_wdata,
  input  logic [NRET-1:0]          rvfi_trap,
  input  logic [NRET*XLEN-1:0]     rvfi_mem_addr,
  input  logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask,
  input  logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]     rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]     rvfi_mem_wdata,
  output logic                     out_valid,
  output logic [ORDER_W-1:0]       out_order,
  output logic [ILEN-1:0]          out_insn,
  output logic [4:0]               out_rs1_addr,
  output logic [4:0]               out_rs2_addr,
  output logic [4:0]               out_rd_addr,
  output logic [XLEN-1:0]          out_pc_rdata,
  output logic [XLEN-1:0]          out_post_pc,
  output logic [XLEN-1:0]          out_rs1_rdata,
  output logic [XLEN-1:0]          out_rs2_rdata,
  output logic [XLEN-1:0]          out_rd_wdata,
  output logic                     out_trap,
  output logic [XLEN-1:0]          out_mem_addr,
  output logic [XLEN/8-1:0]        out_mem_rmask,
  output logic [XLEN/8-1:0]        out_mem_wmask,
  output logic [XLEN-1:0]          out_mem_rdata,
  output logic [XLEN-1:0]          out_mem_wdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_dup,
  output logic                     err_window
);

  localparam int IW = $clog2(DEPTH);
  localparam int MW = XLEN / 8;

  logic [DEPTH-1:0]   slot_vld_q, slot_vld_d;
  rvfi_pkt_t          slot_q [DEPTH];
  logic [ORDER_W-1:0] expected_q, expected_d;
  logic               out_vld_q, out_vld_d;
  rvfi_pkt_t          out_q, out_d;
  logic [IW:0]        occ_q, occ_d;
  logic               err_dup_q, err_dup_d;
  logic               err_win_q, err_win_d;

  rvfi_pkt_t          lane_pkt [NRET];
  logic [NRET-1:0]    acc, dup, win_err, wr;
  logic [NRET-1:0]    byp_sel;
  rvfi_pkt_t          byp_pkt;
  logic [IW-1:0]      head_idx;
  logic               head_vld, byp_hit;

  for (genvar g = 0; g < NRET; g++) begin : g_lane
    logic [ORDER_W-1:0] diff;
    logic               in_win, occ_hit, lower_hit;
    logic [NRET-1:0]    lower_sel;

    assign lane_pkt[g] = '{
      order:     rvfi_order[lane_lsb(g, ORDER_W) +: ORDER_W],
      insn:      rvfi_insn[lane_lsb(g, ILEN) +: ILEN],
      rs1_addr:  rvfi_rs1_addr[lane_lsb(g, 5) +: 5],
      rs2_addr:  rvfi_rs2_addr[lane_lsb(g, 5) +: 5],
      rd_addr:   rvfi_rd_addr[lane_lsb(g, 5) +: 5],
      pc_rdata:  rvfi_pc_rdata[lane_lsb(g, XLEN) +: XLEN],
      post_pc:   rvfi_post_pc[lane_lsb(g, XLEN) +: XLEN],
      rs1_rdata: rvfi_rs1_rdata[lane_lsb(g, XLEN) +: XLEN],
      rs2_rdata: rvfi_rs2_rdata[lane_lsb(g, XLEN) +: XLEN],
      rd_wdata:  rvfi_rd_wdata[lane_lsb(g, XLEN) +: XLEN],
      trap:      rvfi_trap[g],
      mem_addr:  rvfi_mem_addr[lane_lsb(g, XLEN) +: XLEN],
      mem_rmask: rvfi_mem_rmask[lane_lsb(g, MW) +: MW],
      mem_wmask: rvfi_mem_wmask[lane_lsb(g, MW) +: MW],
      mem_rdata: rvfi_mem_rdata[lane_lsb(g, XLEN) +: XLEN],
      mem_wdata: rvfi_mem_wdata[lane_lsb(g, XLEN) +: XLEN]
    };

    // Mod-256 distance from the head of the window decides in/out of window.
    assign diff    = lane_pkt[g].order - expected_q;
    assign in_win  = diff < ORDER_W'(DEPTH);
    assign occ_hit = slot_vld_q[lane_pkt[g].order[IW-1:0]];

    rvfi_lane_pick #(.NRET(NRET)) u_dup_pick (
      .cand_i   (rvfi_valid & ~({NRET{1'b1}} << g)),
      .order_i  (rvfi_order),
      .target_i (lane_pkt[g].order),
      .sel_o    (lower_sel)
    );
    assign lower_hit = |lower_sel;

    assign acc[g]     = rvfi_valid[g] & in_win & ~occ_hit & ~lower_hit;
    assign dup[g]     = rvfi_valid[g] & in_win & (occ_hit | lower_hit);
    assign win_err[g] = rvfi_valid[g] & ~in_win;
    assign wr[g]      = acc[g] & ~byp_sel[g];
  end

  rvfi_lane_pick #(.NRET(NRET)) u_byp_pick (
    .cand_i   (acc),
    .order_i  (rvfi_order),
    .target_i (expected_q),
    .sel_o    (byp_sel)
  );

  assign byp_hit  = |byp_sel;
  assign head_idx = expected_q[IW-1:0];
  assign head_vld = slot_vld_q[head_idx];

  always_comb begin
    byp_pkt = '0;
    for (int i = 0; i < NRET; i++) begin
      if (byp_sel[i]) byp_pkt = lane_pkt[i];
    end
  end

  // A buffered head and a bypass lane are mutually exclusive: that lane would be a dup.
  always_comb begin
    out_vld_d  = head_vld | byp_hit;
    out_d      = out_q;
    expected_d = expected_q;
    if (head_vld) begin
      out_d      = slot_q[head_idx];
      expected_d = expected_q + 1'b1;
    end else if (byp_hit) begin
      out_d      = byp_pkt;
      expected_d = expected_q + 1'b1;
    end
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    if (head_vld) slot_vld_d[head_idx] = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (wr[i]) slot_vld_d[lane_pkt[i].order[IW-1:0]] = 1'b1;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int s = 0; s < DEPTH; s++) begin
      occ_d = occ_d + (IW+1)'(slot_vld_d[s]);
    end
  end

  assign err_dup_d = err_dup_q | (|dup);
  assign err_win_d = err_win_q | (|win_err);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (wr[i]) slot_q[lane_pkt[i].order[IW-1:0]] <= lane_pkt[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_vld_q <= '0;
      expected_q <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      occ_q      <= '0;
      err_dup_q  <= 1'b0;
      err_win_q  <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      expected_q <= expected_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      occ_q      <= occ_d;
      err_dup_q  <= err_dup_d;
      err_win_q  <= err_win_d;
    end
  end

  assign out_valid     = out_vld_q;
  assign out_order     = out_q.order;
  assign out_insn      = out_q.insn;
  assign out_rs1_addr  = out_q.rs1_addr;
  assign out_rs2_addr  = out_q.rs2_addr;
  assign out_rd_addr   = out_q.rd_addr;
  assign out_pc_rdata  = out_q.pc_rdata;
  assign out_post_pc   = out_q.post_pc;
  assign out_rs1_rdata = out_q.rs1_rdata;
  assign out_rs2_rdata = out_q.rs2_rdata;
  assign out_rd_wdata  = out_q.rd_wdata;
  assign out_trap      = out_q.trap;
  assign out_mem_addr  = out_q.mem_addr;
  assign out_mem_rmask = out_q.mem_rmask;
  assign out_mem_wmask = out_q.mem_wmask;
  assign out_mem_rdata = out_q.mem_rdata;
  assign out_mem_wdata = out_q.mem_wdata;
  assign occupancy     = occ_q;
  assign err_dup       = err_dup_q;
  assign err_window    = err_win_q;

endmodule
